// File: rtl/signature_uart_tx.sv
// signature_uart_tx
// Pulls a serial signature MSB-first from an external bit source, eight bits
// per character, and sends each assembled byte on a UART 8N1 line, LSB first.
// One request sends NUM_CHARS characters and ends with a one-cycle done pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | line idle high, waiting for start
// LOAD     | one cycle with sig_ld high, reloads the source to bit 319
// GATHER   | eight cycles with sig_en high, shifting source bits into shreg
// START    | UART start bit (tx low) for CLKS_PER_BIT cycles
// DATA     | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP     | UART stop bit (tx high) for CLKS_PER_BIT cycles
// FINISH   | one cycle with done high, then back to IDLE

module signature_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int NUM_CHARS    = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic sig_bit,
    output logic sig_ld,
    output logic sig_en,
    output logic tx,
    output logic busy,
    output logic done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [5:0] CHAR_LAST = 6'(NUM_CHARS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GATHER,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_FINISH
    } state_t;

    state_t            state;
    logic [5:0]        char_cnt;
    logic [2:0]        bit_cnt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [7:0]        shreg;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    // Sequencer: state, counters, shift register and all registered outputs.
    // Outputs are assigned alongside the transition into each state so they
    // line up with the registered state without any decode from inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            char_cnt <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            sig_ld   <= 1'b0;
            sig_en   <= 1'b0;
        end else begin
            sig_ld <= 1'b0;
            sig_en <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    if (start) begin
                        state  <= ST_LOAD;
                        sig_ld <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    char_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= ST_GATHER;
                    sig_en   <= 1'b1;
                end
                ST_GATHER: begin
                    // The source advances on this same edge, so the bit
                    // captured here is the one it presented beforehand.
                    shreg <= {shreg[6:0], sig_bit};
                    if (bit_cnt == 3'd7) begin
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        state    <= ST_START;
                        tx       <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        sig_en  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= ST_STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[bit_cnt + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (char_cnt == CHAR_LAST) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            char_cnt <= char_cnt + 6'd1;
                            state    <= ST_GATHER;
                            sig_en   <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signature_uart_tx.sv
// Bench for signature_uart_tx: a banner instance (CLKS_PER_BIT=4, 40 chars)
// fed by a behavioural signature source, and a single-character instance
// (CLKS_PER_BIT=2) fed by an 8-bit pattern stub with random patterns.
// Every cycle's {tx,busy,done,sig_ld,sig_en} is compared with a reference
// computed arithmetically from the request timeline.

module tb_signature_uart_tx;

    localparam logic [319:0] BANNER = "Luke Vassallo Tiny Tapeout 2023/03/24.\r\n";
    localparam logic [4:0]   IDLE_V = 5'b10000;
    localparam int           PER_A  = 2 + 40 * (8 + 10 * 4);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic sig_bit_a, sig_ld_a, sig_en_a, tx_a, busy_a, done_a;
    logic sig_bit_b, sig_ld_b, sig_en_b, tx_b, busy_b, done_b;

    int   vec_cnt = 0;
    int   mis_cnt = 0;
    logic txq[$];
    logic [7:0] rx[$];

    always #5 clk = ~clk;

    signature_uart_tx #(.CLKS_PER_BIT(4), .NUM_CHARS(40)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sig_bit(sig_bit_a),
        .sig_ld(sig_ld_a), .sig_en(sig_en_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    signature_uart_tx #(.CLKS_PER_BIT(2), .NUM_CHARS(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sig_bit(sig_bit_b),
        .sig_ld(sig_ld_b), .sig_en(sig_en_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    // Signature source: reload to bit 319, count down and wrap, MSB first.
    logic [8:0] idx_a = 9'd0;
    always @(posedge clk) begin
        if (sig_ld_a)      idx_a <= 9'd319;
        else if (sig_en_a) idx_a <= (idx_a == 9'd0) ? 9'd319 : idx_a - 9'd1;
    end
    assign sig_bit_a = BANNER[idx_a];

    // Pattern stub: eight-bit source presenting pat_b MSB first.
    logic [7:0] pat_b = 8'hA5;
    logic [2:0] idx_b = 3'd0;
    always @(posedge clk) begin
        if (sig_ld_b)      idx_b <= 3'd7;
        else if (sig_en_b) idx_b <= idx_b - 3'd1;
    end
    assign sig_bit_b = pat_b[idx_b];

    // Expected {tx,busy,done,sig_ld,sig_en} k cycles after the edge that
    // accepted start (k=0 is the LOAD cycle).
    function automatic logic [4:0] exp_vec(input int k, input int c, input int n,
                                           input logic [319:0] data);
        int len, last, ch, off, slot;
        logic [7:0] b;
        logic txv;
        len  = 8 + 10 * c;
        last = 1 + n * len;
        if (k == 0)   return 5'b11010;
        if (k > last) return IDLE_V;
        if (k == last) return 5'b11100;
        ch  = (k - 1) / len;
        off = (k - 1) % len;
        if (off < 8) return 5'b11001;
        slot = (off - 8) / c;
        b = data[319 - 8 * ch -: 8];
        if (slot == 0)      txv = 1'b0;
        else if (slot == 9) txv = 1'b1;
        else                txv = b[slot - 1];
        return {txv, 4'b1000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec_cnt++;
        assert (obs === expv)
        else begin
            mis_cnt++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [319:0] obs, input logic [319:0] expv);
        vec_cnt++;
        assert (obs === expv)
        else begin
            mis_cnt++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Independent UART receiver over the per-cycle tx samples in txq.
    task automatic decode(input int c);
        int i;
        logic [7:0] b;
        i = 0;
        rx.delete();
        while (i + 10 * c <= txq.size()) begin
            if (txq[i] === 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = txq[i + c / 2 + c * (j + 1)];
                rx.push_back(b);
                i += c / 2 + 9 * c + 1;
            end else begin
                i++;
            end
        end
    endtask

    // One banner request on instance A; an extra start pulse at cycle poke
    // (if non-negative) must be ignored.
    task automatic req_a(input int poke);
        int done_seen;
        done_seen = 0;
        txq.delete();
        @(negedge clk);
        start_a = 1'b1;
        for (int k = 0; k <= PER_A; k++) begin
            @(negedge clk);
            chk($sformatf("a_cyc%0d", k), 32'({tx_a, busy_a, done_a, sig_ld_a, sig_en_a}),
                32'(exp_vec(k, 4, 40, BANNER)));
            txq.push_back(tx_a);
            if (done_a === 1'b1) done_seen++;
            start_a = (k == poke);
        end
        chk("a_done_count", 32'(done_seen), 32'd1);
        decode(4);
        chk("a_char_count", 32'(rx.size()), 32'd40);
    endtask

    logic [319:0] got;

    initial begin
        int poke;
        repeat (3) @(negedge clk);
        chk("reset_state_a", 32'({tx_a, busy_a, done_a, sig_ld_a, sig_en_a}), 32'(IDLE_V));
        chk("reset_state_b", 32'({tx_b, busy_b, done_b, sig_ld_b, sig_en_b}), 32'(IDLE_V));
        reset = 1'b0;

        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", k), 32'({tx_a, busy_a, done_a, sig_ld_a, sig_en_a}),
                32'(IDLE_V));
        end

        // Reset in the middle of the first character's data bits.
        start_a = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            chk($sformatf("pre_rst%0d", k), 32'({tx_a, busy_a, done_a, sig_ld_a, sig_en_a}),
                32'(exp_vec(k, 4, 40, BANNER)));
        end
        reset = 1'b1;
        #1;
        chk("async_rst_tx_busy", 32'({tx_a, busy_a}), 32'b10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("in_rst%0d", k), 32'({tx_a, busy_a, done_a, sig_ld_a, sig_en_a}),
                32'(IDLE_V));
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d", k), 32'({tx_a, busy_a, done_a, sig_ld_a, sig_en_a}),
                32'(IDLE_V));
        end

        // Full banner from a single start pulse.
        req_a(-1);
        chk("byte0", 32'(rx[0]), 32'h4C);
        chk("byte1", 32'(rx[1]), 32'h75);
        chk("byte39", 32'(rx[39]), 32'h0A);
        for (int i = 0; i < 40; i++) got[319 - 8 * i -: 8] = rx[i];
        chk_wide("banner", got, BANNER);

        // Start pulse during character 5 is ignored.
        poke = int'($urandom_range(1 + 5 * 48, 6 * 48));
        req_a(poke);
        for (int i = 0; i < 40; i++) got[319 - 8 * i -: 8] = rx[i];
        chk_wide("banner_poke", got, BANNER);

        // start held high: two back-to-back banners with one idle cycle.
        txq.delete();
        @(negedge clk);
        start_a = 1'b1;
        for (int k = 0; k < 2 * (PER_A + 1); k++) begin
            @(negedge clk);
            chk($sformatf("held%0d", k), 32'({tx_a, busy_a, done_a, sig_ld_a, sig_en_a}),
                32'(exp_vec(k % (PER_A + 1), 4, 40, BANNER)));
            txq.push_back(tx_a);
            if (k == PER_A + 10) start_a = 1'b0;
        end
        decode(4);
        chk("held_char_count", 32'(rx.size()), 32'd80);
        chk("held_second_byte0", 32'(rx[40]), 32'h4C);
        for (int i = 0; i < 40; i++) got[319 - 8 * i -: 8] = rx[40 + i];
        chk_wide("held_banner2", got, BANNER);

        // Single-character instance: 0xA5 first, then random patterns.
        for (int r = 0; r < 8; r++) begin
            pat_b = (r == 0) ? 8'hA5 : 8'($urandom);
            txq.delete();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_b = 1'b1;
            for (int k = 0; k <= 32; k++) begin
                @(negedge clk);
                start_b = 1'b0;
                chk($sformatf("b%0d_cyc%0d", r, k),
                    32'({tx_b, busy_b, done_b, sig_ld_b, sig_en_b}),
                    32'(exp_vec(k, 2, 1, {pat_b, 312'b0})));
                txq.push_back(tx_b);
            end
            decode(2);
            chk($sformatf("b%0d_count", r), 32'(rx.size()), 32'd1);
            if (rx.size() > 0) chk($sformatf("b%0d_byte", r), 32'(rx[0]), 32'(pat_b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
